// File: rtl/channel_voice_generator_pkg.sv
// Shared voice definitions: compare field width, default duty, envelope
// width and the magnitude shift rule. The note sequencer imports the same
// package so both ends agree on these values.
package channel_voice_generator_pkg;

    localparam int         CMP_W        = 7;
    localparam logic [7:0] DUTY_DEFAULT = 8'hff;
    localparam int         ENV_W        = 9;

    // Left shift that places {1'b0, env} at the top of a signed sample.
    function automatic int mag_shift(input int sample_w);
        return sample_w - (ENV_W + 1);
    endfunction

endpackage

// File: rtl/channel_voice_generator_phase_acc.sv
// Phase accumulator: advances by delta on each strobe, wraps silently.
// A clear overrides the strobe increment.
module phase_accumulator #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stb,
    input  logic [ACC_W-1:0] delta,
    input  logic             clr,
    output logic [ACC_W-1:0] phase
);

    // Phase register: reset/clear to zero, otherwise add delta on strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (stb) begin
            phase <= phase + delta;
        end
    end

endmodule

// File: rtl/channel_voice_generator.sv
// Pulse-wave voice stage. Three-stage pipeline: phase advance and envelope
// capture, duty compare, envelope scaling to a signed sample.
// Optional feature macro: CHANNEL_VOICE_PHASE_RST_EN adds i_phase_rst,
// which clears the phase accumulator.
module channel_voice_generator
    import channel_voice_generator_pkg::*;
#(
    parameter int ACC_W    = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sample_stb,
    input  logic [ACC_W-1:0]    i_phase_delta,
    input  logic [ENV_W-1:0]    i_envelope,
    input  logic [7:0]          i_top,
    input  logic                i_top_valid,
`ifdef CHANNEL_VOICE_PHASE_RST_EN
    input  logic                i_phase_rst,
`endif
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_sample_valid
);

    logic [ACC_W-1:0]    phase;
    logic                phase_clr;
    logic [7:0]          duty_q;
    logic [ENV_W-1:0]    env_s1;
    logic [ENV_W-1:0]    env_s2;
    logic                v1;
    logic                v2;
    logic                level_s2;
    logic [7:0]          thr;
    logic [7:0]          cmp_val;
    logic [SAMPLE_W-1:0] mag;

`ifdef CHANNEL_VOICE_PHASE_RST_EN
    assign phase_clr = i_phase_rst;
`else
    assign phase_clr = 1'b0;
`endif

    phase_accumulator #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .stb   (i_sample_stb),
        .delta (i_phase_delta),
        .clr   (phase_clr),
        .phase (phase)
    );

    // Threshold spans 1..128 across the 8-bit range. The 7-bit phase field is
    // left-aligned into that range, so thr=128 is a half period (50% square)
    // and thr=1 only admits field 0 (1/128 high).
    assign thr     = {1'b0, duty_q[7:1]} + 8'd1;
    assign cmp_val = {phase[ACC_W-1 -: CMP_W], {(8-CMP_W){1'b0}}};
    assign mag     = SAMPLE_W'({1'b0, env_s2}) << mag_shift(SAMPLE_W);

    // Duty register: loads whenever the sequencer presents a valid top.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            duty_q <= DUTY_DEFAULT;
        end else if (i_top_valid) begin
            duty_q <= i_top;
        end
    end

    // S1: capture envelope alongside the phase advance.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            env_s1 <= '0;
            v1     <= 1'b0;
        end else begin
            v1 <= i_sample_stb;
            if (i_sample_stb) begin
                env_s1 <= i_envelope;
            end
        end
    end

    // S2: pulse level from the advanced phase against the duty threshold.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            env_s2   <= '0;
            level_s2 <= 1'b0;
            v2       <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                env_s2   <= env_s1;
                level_s2 <= (cmp_val < thr);
            end
        end
    end

    // S3: signed sample; held between valid pulses.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
        end else begin
            o_sample_valid <= v2;
            if (v2) begin
                o_sample <= level_s2 ? mag : (~mag + 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_channel_voice_generator.sv
// Scoreboard bench for channel_voice_generator: stimulus pushes expected
// samples, a negedge monitor pops and compares on each valid pulse.
module tb_channel_voice_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb;
    logic [31:0] delta;
    logic [8:0]  env;
    logic [7:0]  top;
    logic        top_valid;
`ifdef CHANNEL_VOICE_PHASE_RST_EN
    logic        phase_rst;
`endif
    logic [15:0] o_sample;
    logic        o_sample_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    logic [15:0] exp_q[$];

    localparam logic [15:0] POS20  = 16'd1280;
    localparam logic [15:0] NEG20  = 16'hFB00;
    localparam logic [15:0] POS511 = 16'd32704;
    localparam logic [15:0] NEG511 = 16'h8040;

    channel_voice_generator #(
        .ACC_W    (32),
        .SAMPLE_W (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sample_stb   (stb),
        .i_phase_delta  (delta),
        .i_envelope     (env),
        .i_top          (top),
        .i_top_valid    (top_valid),
`ifdef CHANNEL_VOICE_PHASE_RST_EN
        .i_phase_rst    (phase_rst),
`endif
        .o_sample       (o_sample),
        .o_sample_valid (o_sample_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        stb       = 1'b0;
        top_valid = 1'b0;
        repeat (5) tick();
    endtask

    // Monitor: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (o_sample_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got sample %h expected no pulse at %0t", o_sample, $time);
            end else begin
                check("sample", {16'h0, o_sample}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int vcount;
        rst_n     = 1'b0;
        stb       = 1'b0;
        delta     = '0;
        env       = '0;
        top       = '0;
        top_valid = 1'b0;
`ifdef CHANNEL_VOICE_PHASE_RST_EN
        phase_rst = 1'b0;
`endif
        repeat (3) tick();
        check("rst_sample", {16'h0, o_sample}, 32'h0);
        check("rst_valid", {31'h0, o_sample_valid}, 32'h0);
        check("rst_phase", dut.u_phase_acc.phase, 32'h0);
        rst_n = 1'b1;
        tick();

        // Test 1: 50% square, field steps by 1 per sample.
        stb   = 1'b1;
        delta = 32'h0200_0000;
        env   = 9'd20;
        for (int i = 1; i <= 128; i++) begin
            exp_q.push_back(((i % 128) < 64) ? POS20 : NEG20);
            tick();
            if (i == 1 || i == 2) check("latency_early", {31'h0, o_sample_valid}, 32'h0);
            if (i == 3) check("latency_first", {31'h0, o_sample_valid}, 32'h1);
        end
        drain();
        check("t1_phase_wrap", dut.u_phase_acc.phase, 32'h0);

        // Test 2: half-turn delta wraps.
        stb   = 1'b1;
        delta = 32'h8000_0000;
        exp_q.push_back(NEG20);
        tick();
        check("t2_phase_a", dut.u_phase_acc.phase, 32'h8000_0000);
        exp_q.push_back(POS20);
        tick();
        check("t2_phase_b", dut.u_phase_acc.phase, 32'h0);
        drain();

        // Test 3: duty 00 loaded with the strobe applies to that sample.
        stb       = 1'b1;
        delta     = 32'h0;
        top       = 8'h00;
        top_valid = 1'b1;
        exp_q.push_back(POS20);
        tick();
        top_valid = 1'b0;
        delta     = 32'h0200_0000;
        exp_q.push_back(NEG20);
        tick();
        stb       = 1'b0;
        top       = 8'hff;
        top_valid = 1'b1;
        tick();
        drain();

        // Test 4: env=0 yields zero but still pulses; then full-scale env.
        stb   = 1'b1;
        env   = 9'd0;
        delta = 32'h4000_0000;
        repeat (3) begin
            exp_q.push_back(16'h0);
            tick();
        end
        env   = 9'd511;
        delta = 32'h0;
        exp_q.push_back(NEG511);
        tick();
        delta = 32'h3E00_0000;
        exp_q.push_back(POS511);
        tick();
        drain();
        check("t4_phase", dut.u_phase_acc.phase, 32'h0);

        // Test 5: reset while samples are in flight drops them all.
        vcount    = n_valid;
        env       = 9'd20;
        delta     = 32'h0200_0000;
        stb       = 1'b1;
        top       = 8'h00;
        top_valid = 1'b1;
        tick();
        top_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("t5_sample", {16'h0, o_sample}, 32'h0);
        check("t5_phase", dut.u_phase_acc.phase, 32'h0);
        rst_n = 1'b1;
        stb   = 1'b0;
        repeat (5) tick();
        check("t5_no_valid", n_valid, vcount);
        // Duty must be back at its default: field 1 is high.
        stb = 1'b1;
        exp_q.push_back(POS20);
        tick();
        drain();

`ifdef CHANNEL_VOICE_PHASE_RST_EN
        // Test 6: phase reset overrides a coincident strobe.
        stb   = 1'b1;
        delta = 32'h3E00_0000;
        exp_q.push_back(POS20);
        tick();
        check("t6_phase_pre", dut.u_phase_acc.phase, 32'h4000_0000);
        phase_rst = 1'b1;
        delta     = 32'h1234_5678;
        exp_q.push_back(POS20);
        tick();
        phase_rst = 1'b0;
        check("t6_phase_clr", dut.u_phase_acc.phase, 32'h0);
        drain();
`endif

        check("queue_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
